// File: rtl/gqa_pkg.sv
// Shared types and size helpers for the GQA head scheduler.
package gqa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_KV,
    S_RUN_HEAD,
    S_RELEASE,
    S_DONE
  } gqa_state_t;

  function automatic int unsigned beats_per_head(
    input int unsigned dim_1,
    input int unsigned par_dim_1,
    input int unsigned head_dim,
    input int unsigned weight_par_dim_0
  );
    return (dim_1 / par_dim_1) * (head_dim / weight_par_dim_0);
  endfunction

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gqa_head_counter.sv
// Nested beat -> head-in-group -> group counter chain with a registered head_id.
module gqa_head_counter
  import gqa_pkg::*;
#(
  parameter int unsigned BEATS_PER_HEAD = 80,
  parameter int unsigned GROUP_SIZE     = 4,
  parameter int unsigned NUM_GROUPS     = 3,
  parameter int unsigned NUM_HEADS      = 12,
  localparam int unsigned GW = cnt_width(NUM_GROUPS),
  localparam int unsigned HW = cnt_width(NUM_HEADS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          beat_inc,
  input  logic          group_inc,
  output logic          head_wrap,
  output logic          group_last,
  output logic [GW-1:0] group_cnt,
  output logic [HW-1:0] head_id
);

  localparam int unsigned BW  = cnt_width(BEATS_PER_HEAD);
  localparam int unsigned HCW = cnt_width(GROUP_SIZE);

  logic [BW-1:0]  beat_cnt, beat_nxt;
  logic [HCW-1:0] head_cnt, head_nxt;
  logic [GW-1:0]  group_nxt;
  logic           beat_last, head_last;

  assign beat_last  = (beat_cnt == BW'(BEATS_PER_HEAD - 1));
  assign head_last  = (head_cnt == HCW'(GROUP_SIZE - 1));
  assign group_last = (group_cnt == GW'(NUM_GROUPS - 1));
  assign head_wrap  = beat_inc & beat_last & head_last;

  // The last head of a group holds its index through RELEASE so head_id
  // keeps naming the group being released; group_inc moves to the next one.
  always_comb begin
    beat_nxt  = beat_cnt;
    head_nxt  = head_cnt;
    group_nxt = group_cnt;
    if (clear) begin
      beat_nxt  = '0;
      head_nxt  = '0;
      group_nxt = '0;
    end else begin
      if (beat_inc) begin
        if (beat_last) begin
          beat_nxt = '0;
          if (!head_last) head_nxt = head_cnt + 1'b1;
        end else begin
          beat_nxt = beat_cnt + 1'b1;
        end
      end
      if (group_inc) begin
        head_nxt  = '0;
        group_nxt = group_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt  <= '0;
      head_cnt  <= '0;
      group_cnt <= '0;
      head_id   <= '0;
    end else begin
      beat_cnt  <= beat_nxt;
      head_cnt  <= head_nxt;
      group_cnt <= group_nxt;
      head_id   <= HW'(group_nxt) * HW'(GROUP_SIZE) + HW'(head_nxt);
    end
  end

endmodule

// File: rtl/gqa_head_scheduler.sv
// Walks all query heads group by group, loading each KV group once and gating the query stream.
module gqa_head_scheduler
  import gqa_pkg::*;
#(
  parameter int unsigned NUM_HEADS                   = 12,
  parameter int unsigned NUM_GROUPS                  = 3,
  parameter int unsigned DATA_IN_0_TENSOR_SIZE_DIM_1 = 20,
  parameter int unsigned DATA_IN_0_PARALLELISM_DIM_1 = 4,
  parameter int unsigned HEAD_DIM                    = 64,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_0    = 4,
  localparam int unsigned GW = cnt_width(NUM_GROUPS),
  localparam int unsigned HW = cnt_width(NUM_HEADS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          kv_load_valid,
  input  logic          kv_load_ready,
  output logic [GW-1:0] kv_group,
  output logic [HW-1:0] head_id,
  output logic          kv_release,
  input  logic          q_in_valid,
  output logic          q_in_ready,
  output logic          q_out_valid,
  input  logic          q_out_ready
);

  localparam int unsigned GROUP_SIZE = NUM_HEADS / NUM_GROUPS;
  localparam int unsigned BEATS_PER_HEAD = beats_per_head(
    DATA_IN_0_TENSOR_SIZE_DIM_1, DATA_IN_0_PARALLELISM_DIM_1,
    HEAD_DIM, WEIGHT_PARALLELISM_DIM_0);

  gqa_state_t state;
  logic       run_head;
  logic       beat_inc, group_inc, clear;
  logic       head_wrap, group_last;

  assign q_out_valid = run_head & q_in_valid;
  assign q_in_ready  = run_head & q_out_ready;
  assign beat_inc    = run_head & q_in_valid & q_out_ready;
  assign group_inc   = (state == S_RELEASE) & ~group_last;
  assign clear       = ((state == S_IDLE) & start) | (state == S_DONE);

  gqa_head_counter #(
    .BEATS_PER_HEAD (BEATS_PER_HEAD),
    .GROUP_SIZE     (GROUP_SIZE),
    .NUM_GROUPS     (NUM_GROUPS),
    .NUM_HEADS      (NUM_HEADS)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .beat_inc   (beat_inc),
    .group_inc  (group_inc),
    .head_wrap  (head_wrap),
    .group_last (group_last),
    .group_cnt  (kv_group),
    .head_id    (head_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      kv_load_valid <= 1'b0;
      kv_release    <= 1'b0;
      run_head      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_LOAD_KV;
            busy          <= 1'b1;
            kv_load_valid <= 1'b1;
          end
        end
        S_LOAD_KV: begin
          if (kv_load_valid && kv_load_ready) begin
            state         <= S_RUN_HEAD;
            kv_load_valid <= 1'b0;
            run_head      <= 1'b1;
          end
        end
        S_RUN_HEAD: begin
          if (head_wrap) begin
            state      <= S_RELEASE;
            run_head   <= 1'b0;
            kv_release <= 1'b1;
          end
        end
        S_RELEASE: begin
          kv_release <= 1'b0;
          if (group_last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state         <= S_LOAD_KV;
            kv_load_valid <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gqa_head_scheduler.sv
// Scoreboard bench for gqa_head_scheduler: 4 heads, 2 groups, 2 beats per head.
module tb_gqa_head_scheduler;

  localparam int unsigned NH  = 4;
  localparam int unsigned NG  = 2;
  localparam int unsigned GS  = NH / NG;
  localparam int unsigned BPH = 2;

  logic       clk = 1'b0;
  logic       rst, start, kv_load_ready, q_in_valid, q_out_ready;
  logic       busy, done, kv_load_valid, kv_release, q_in_ready, q_out_valid;
  logic [0:0] kv_group;
  logic [1:0] head_id;

  int errors = 0;
  int checks = 0;
  int exp_head[$];
  int exp_grp[$];

  gqa_head_scheduler #(
    .NUM_HEADS                   (NH),
    .NUM_GROUPS                  (NG),
    .DATA_IN_0_TENSOR_SIZE_DIM_1 (4),
    .DATA_IN_0_PARALLELISM_DIM_1 (4),
    .HEAD_DIM                    (8),
    .WEIGHT_PARALLELISM_DIM_0    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .kv_load_valid (kv_load_valid),
    .kv_load_ready (kv_load_ready),
    .kv_group      (kv_group),
    .head_id       (head_id),
    .kv_release    (kv_release),
    .q_in_valid    (q_in_valid),
    .q_in_ready    (q_in_ready),
    .q_out_valid   (q_out_valid),
    .q_out_ready   (q_out_ready)
  );

  always #5 clk = ~clk;

  task automatic push_pass();
    exp_head.delete();
    exp_grp.delete();
    for (int g = 0; g < int'(NG); g++) begin
      exp_grp.push_back(g);
      for (int h = 0; h < int'(GS); h++)
        for (int b = 0; b < int'(BPH); b++)
          exp_head.push_back(g * int'(GS) + h);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [7:0] obs;
    obs = {busy, done, kv_load_valid, kv_release, q_out_valid, q_in_ready, head_id};
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL %s_outputs: got %b expected 00000000", tag, obs);
    end
    checks++;
    if (kv_group !== 1'b0) begin
      errors++;
      $display("FAIL %s_kv_group: got %0d expected 0", tag, kv_group);
    end
  endtask

  // mode: 0 all ready, 1 kv_load_ready stalled 5 cycles, 2 random stalls,
  //       3 start poked mid-run, 4 stop after 3 beats (caller resets)
  task automatic run_pass(input int mode, input string tag);
    int beats = 0, rels = 0, last_rel = -10, cyc = 0, got;
    bit seen_done = 1'b0, poked = 1'b0, prev_stall = 1'b0;
    logic [1:0] prev_head = '0;
    push_pass();
    @(negedge clk);
    start = 1'b1; kv_load_ready = 1'b1; q_in_valid = 1'b1; q_out_ready = 1'b1;
    while (!seen_done && cyc < 400) begin
      cyc++;
      @(negedge clk);
      start = 1'b0;
      if (mode == 3 && beats >= 1 && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
      kv_load_ready = !(mode == 1 && cyc <= 5);
      if (mode == 2) begin
        q_in_valid  = 1'($urandom_range(0, 1));
        q_out_ready = 1'($urandom_range(0, 1));
      end
      #1;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy cyc %0d: got %b expected 1", tag, cyc, busy);
      end
      if (mode == 1 && cyc <= 5) begin
        checks++;
        if ({kv_load_valid, kv_group, q_in_ready} !== 3'b100) begin
          errors++;
          $display("FAIL %s_kv_stall cyc %0d: got valid=%b group=%0d q_in_ready=%b expected 1,0,0",
                   tag, cyc, kv_load_valid, kv_group, q_in_ready);
        end
      end
      if (prev_stall) begin
        checks++;
        if (head_id !== prev_head) begin
          errors++;
          $display("FAIL %s_head_stable cyc %0d: got %0d expected %0d", tag, cyc, head_id, prev_head);
        end
      end
      if (q_out_valid) begin
        checks++;
        if (q_in_ready !== q_out_ready) begin
          errors++;
          $display("FAIL %s_ready_pass cyc %0d: got %b expected %b", tag, cyc, q_in_ready, q_out_ready);
        end
      end
      if (kv_load_valid && kv_load_ready) begin
        checks++;
        if (exp_grp.size() == 0) begin
          errors++;
          $display("FAIL %s_kv_load cyc %0d: got group %0d expected no load", tag, cyc, kv_group);
        end else begin
          got = exp_grp.pop_front();
          if (int'(kv_group) !== got) begin
            errors++;
            $display("FAIL %s_kv_load cyc %0d: got group %0d expected %0d", tag, cyc, kv_group, got);
          end
        end
      end
      if (q_out_valid && q_out_ready) begin
        beats++;
        checks++;
        if (exp_head.size() == 0) begin
          errors++;
          $display("FAIL %s_beat cyc %0d: got head %0d expected no beat", tag, cyc, head_id);
        end else begin
          got = exp_head.pop_front();
          if (int'(head_id) !== got) begin
            errors++;
            $display("FAIL %s_beat cyc %0d: got head %0d expected %0d", tag, cyc, head_id, got);
          end
        end
      end
      if (kv_release) begin
        rels++;
        last_rel = cyc;
      end
      if (done) begin
        seen_done = 1'b1;
        checks++;
        if (cyc != last_rel + 1) begin
          errors++;
          $display("FAIL %s_done_timing: got cyc %0d expected %0d", tag, cyc, last_rel + 1);
        end
      end
      prev_stall = q_out_valid && !q_out_ready;
      prev_head  = head_id;
      if (mode == 4 && beats == 3) break;
    end
    start = 1'b0;
    if (mode == 4) begin
      checks++;
      if (beats != 3) begin
        errors++;
        $display("FAIL %s_partial_beats: got %0d expected 3", tag, beats);
      end
      return;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s_timeout: got no done within %0d cycles expected done", tag, cyc);
    end
    checks++;
    if (beats != int'(NH * BPH) || rels != int'(NG)) begin
      errors++;
      $display("FAIL %s_counts: got beats=%0d releases=%0d expected %0d,%0d", tag, beats, rels, NH * BPH, NG);
    end
    checks++;
    if (exp_head.size() != 0 || exp_grp.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d heads %0d groups pending expected 0,0",
               tag, exp_head.size(), exp_grp.size());
    end
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL %s_after_done: got busy=%b done=%b expected 0,0", tag, busy, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; kv_load_ready = 1'b1; q_in_valid = 1'b1; q_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    #1;
    check_idle_outputs("post_reset");
  endtask

  task automatic test_basic_pass();
    run_pass(0, "basic");
  endtask

  task automatic test_kv_stall();
    run_pass(1, "kv_stall");
  endtask

  task automatic test_random_stalls();
    for (int i = 0; i < 3; i++) run_pass(2, "random");
    q_in_valid = 1'b1; q_out_ready = 1'b1;
  endtask

  task automatic test_start_while_busy();
    run_pass(3, "start_busy");
  endtask

  task automatic test_reset_mid_pass();
    run_pass(4, "mid_reset");
    @(negedge clk);
    rst = 1'b1; q_in_valid = 1'b1; q_out_ready = 1'b1; kv_load_ready = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("mid_reset");
    rst = 1'b0;
    run_pass(0, "restart");
  endtask

  task automatic test_back_to_back();
    run_pass(0, "b2b_a");
    run_pass(0, "b2b_b");
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_kv_stall();
    test_random_stalls();
    test_start_while_busy();
    test_reset_mid_pass();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
